// File: rtl/scarv_cop_pkg.sv
// scarv_cop_pkg: shared constants and types for the crypto coprocessor.
// Opcode, funct3 codes, result codes, FSM states and LFSR helpers.
package scarv_cop_pkg;

    localparam logic [6:0]  COP_OPCODE = 7'b0101011;
    localparam int          CPR_COUNT  = 16;
    localparam int          CPR_AW     = 4;

    typedef enum logic [2:0] {
        F3_MV2COP  = 3'd0,
        F3_MV2GPR  = 3'd1,
        F3_LDW     = 3'd2,
        F3_STW     = 3'd3,
        F3_RNGSAMP = 3'd4,
        F3_ADD     = 3'd5,
        F3_XOR     = 3'd6,
        F3_INV     = 3'd7
    } cop_funct3_t;

    localparam logic [2:0] RES_OK       = 3'd0;
    localparam logic [2:0] RES_ABORT    = 3'd1;
    localparam logic [2:0] RES_BUS_ERR  = 3'd2;
    localparam logic [2:0] RES_MISALIGN = 3'd3;
    localparam logic [2:0] RES_INVALID  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXEC    = 3'd1,
        ST_MEM_REQ = 3'd2,
        ST_MEM_RSP = 3'd3,
        ST_RSP     = 3'd4
    } cop_state_t;

    // Decoded fields kept for the life of one instruction.
    typedef struct packed {
        logic              valid;
        cop_funct3_t       f3;
        logic [4:0]        rd;
        logic [CPR_AW-1:0] cs1;
        logic [CPR_AW-1:0] cs2;
    } cop_insn_t;

    // Galois form of x^32 + x^22 + x^2 + x + 1 (right shifting).
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

    // Word offset from the top byte of the encoding, sign extended.
    function automatic logic [31:0] mem_off(input logic [31:0] enc);
        return {{22{enc[31]}}, enc[31:24], 2'b00};
    endfunction

    function automatic cop_insn_t decode(input logic [31:0] enc);
        cop_insn_t d;
        d.valid = (enc[6:0] == COP_OPCODE) && (enc[14:12] != 3'd7);
        d.f3    = cop_funct3_t'(enc[14:12]);
        d.rd    = enc[11:7];
        d.cs1   = enc[19:16];
        d.cs2   = enc[23:20];
        return d;
    endfunction

endpackage

// File: rtl/scarv_cop_cprs.sv
// scarv_cop_cprs: 16x32 coprocessor register file.
// Two combinational read ports, one synchronous write port.
module scarv_cop_cprs
    import scarv_cop_pkg::*;
(
    input  logic              g_clk,
    input  logic              g_resetn,
    input  logic [CPR_AW-1:0] rs1_addr,
    output logic [31:0]       rs1_data,
    input  logic [CPR_AW-1:0] rs2_addr,
    output logic [31:0]       rs2_data,
    input  logic              wen,
    input  logic [CPR_AW-1:0] waddr,
    input  logic [31:0]       wdata
);

    logic [31:0] regs [CPR_COUNT];

    // Clear on reset, otherwise write one register per cycle.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            for (int i = 0; i < CPR_COUNT; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (wen) begin
            regs[waddr] <= wdata;
        end
    end

    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

endmodule

// File: rtl/scarv_cop_core.sv
// scarv_cop_core: crypto coprocessor subset with CPRs, memory port and
// LFSR random source behind req/ack instruction and rsp/ack result handshakes.
module scarv_cop_core
    import scarv_cop_pkg::*;
#(
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    output logic        g_clk_req,
    input  logic        cpu_insn_req,
    output logic        cop_insn_ack,
    input  logic        cpu_abort_req,
    input  logic [31:0] cpu_insn_enc,
    input  logic [31:0] cpu_rs1,
    output logic        cop_wen,
    output logic [4:0]  cop_waddr,
    output logic [31:0] cop_wdata,
    output logic [2:0]  cop_result,
    output logic        cop_insn_rsp,
    input  logic        cpu_insn_ack,
    output logic [31:0] cop_random,
    output logic        cop_rand_sample,
    output logic        cop_mem_cen,
    output logic        cop_mem_wen,
    output logic [31:0] cop_mem_addr,
    output logic [31:0] cop_mem_wdata,
    input  logic [31:0] cop_mem_rdata,
    output logic [3:0]  cop_mem_ben,
    input  logic        cop_mem_stall,
    input  logic        cop_mem_error
);

    cop_state_t  state;
    cop_insn_t   insn_q;
    cop_insn_t   insn_in;
    logic [31:0] rs1_q;
    logic [31:0] lfsr;

    logic        accept;
    logic        in_mem;
    logic        in_store;
    logic [31:0] in_addr;

    logic [CPR_AW-1:0] cpr_ra1;
    logic [CPR_AW-1:0] cpr_ra2;
    logic [31:0]       cpr_rd1;
    logic [31:0]       cpr_rd2;
    logic              cpr_we;
    logic [31:0]       cpr_wd;

    logic [2:0]  exec_res;
    logic        exec_cpr_we;
    logic        exec_gpr_we;
    logic        exec_rng;
    logic [31:0] exec_wd;

    logic        unused_enc;

    assign unused_enc   = cpu_insn_enc[15];

    assign cop_insn_ack = (state == ST_IDLE);
    assign g_clk_req    = (state != ST_IDLE) || cpu_insn_req;
    assign accept       = cpu_insn_req && cop_insn_ack;
    assign cop_random   = lfsr;

    assign insn_in  = decode(cpu_insn_enc);
    assign in_store = (insn_in.f3 == F3_STW);
    assign in_mem   = insn_in.valid &&
                      ((insn_in.f3 == F3_LDW) || in_store);
    assign in_addr  = cpu_rs1 + mem_off(cpu_insn_enc);

    // In IDLE the read ports look at the incoming encoding so store
    // data is ready at the accept edge.
    assign cpr_ra1 = (state == ST_IDLE) ? insn_in.cs1 : insn_q.cs1;
    assign cpr_ra2 = (state == ST_IDLE) ? insn_in.cs2 : insn_q.cs2;

    scarv_cop_cprs u_cprs (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .rs1_addr (cpr_ra1),
        .rs1_data (cpr_rd1),
        .rs2_addr (cpr_ra2),
        .rs2_data (cpr_rd2),
        .wen      (cpr_we),
        .waddr    (insn_q.rd[3:0]),
        .wdata    (cpr_wd)
    );

    // Evaluate a non-memory instruction (or a misaligned memory op).
    always_comb begin
        exec_res    = RES_OK;
        exec_cpr_we = 1'b0;
        exec_gpr_we = 1'b0;
        exec_rng    = 1'b0;
        exec_wd     = 32'h0;
        if (cpu_abort_req) begin
            exec_res = RES_ABORT;
        end else if (!insn_q.valid) begin
            exec_res = RES_INVALID;
        end else begin
            case (insn_q.f3)
                F3_MV2COP: begin
                    exec_cpr_we = 1'b1;
                    exec_wd     = rs1_q;
                end
                F3_MV2GPR: exec_gpr_we = 1'b1;
                F3_LDW:    exec_res    = RES_MISALIGN;
                F3_STW:    exec_res    = RES_MISALIGN;
                F3_RNGSAMP: begin
                    exec_cpr_we = 1'b1;
                    exec_rng    = 1'b1;
                    exec_wd     = lfsr;
                end
                F3_ADD: begin
                    exec_cpr_we = 1'b1;
                    exec_wd     = cpr_rd1 + cpr_rd2;
                end
                F3_XOR: begin
                    exec_cpr_we = 1'b1;
                    exec_wd     = cpr_rd1 ^ cpr_rd2;
                end
                default:   exec_res    = RES_INVALID;
            endcase
        end
    end

    // CPR writes come from EXEC or from a clean load response.
    always_comb begin
        cpr_we = 1'b0;
        cpr_wd = exec_wd;
        if (state == ST_EXEC) begin
            cpr_we = exec_cpr_we;
        end else if (state == ST_MEM_RSP) begin
            cpr_we = (insn_q.f3 == F3_LDW) && !cop_mem_error;
            cpr_wd = cop_mem_rdata;
        end
    end

    assign cop_rand_sample = (state == ST_EXEC) && exec_rng;

    // Free-running random source.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    // Instruction sequencer with registered handshake and memory outputs.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state         <= ST_IDLE;
            insn_q        <= '0;
            rs1_q         <= 32'h0;
            cop_insn_rsp  <= 1'b0;
            cop_wen       <= 1'b0;
            cop_waddr     <= 5'h0;
            cop_wdata     <= 32'h0;
            cop_result    <= RES_OK;
            cop_mem_cen   <= 1'b0;
            cop_mem_wen   <= 1'b0;
            cop_mem_addr  <= 32'h0;
            cop_mem_wdata <= 32'h0;
            cop_mem_ben   <= 4'h0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        insn_q <= insn_in;
                        rs1_q  <= cpu_rs1;
                        if (in_mem && (in_addr[1:0] == 2'b00)) begin
                            state         <= ST_MEM_REQ;
                            cop_mem_cen   <= 1'b1;
                            cop_mem_wen   <= in_store;
                            cop_mem_addr  <= in_addr;
                            cop_mem_wdata <= in_store ? cpr_rd1 : 32'h0;
                            cop_mem_ben   <= in_store ? 4'hF : 4'h0;
                        end else begin
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    state        <= ST_RSP;
                    cop_insn_rsp <= 1'b1;
                    cop_result   <= exec_res;
                    if (exec_gpr_we) begin
                        cop_wen   <= 1'b1;
                        cop_waddr <= insn_q.rd;
                        cop_wdata <= cpr_rd1;
                    end
                end
                ST_MEM_REQ: begin
                    if (cpu_abort_req || !cop_mem_stall) begin
                        cop_mem_cen   <= 1'b0;
                        cop_mem_wen   <= 1'b0;
                        cop_mem_addr  <= 32'h0;
                        cop_mem_wdata <= 32'h0;
                        cop_mem_ben   <= 4'h0;
                    end
                    if (cpu_abort_req) begin
                        state        <= ST_RSP;
                        cop_insn_rsp <= 1'b1;
                        cop_result   <= RES_ABORT;
                    end else if (!cop_mem_stall) begin
                        state <= ST_MEM_RSP;
                    end
                end
                ST_MEM_RSP: begin
                    state        <= ST_RSP;
                    cop_insn_rsp <= 1'b1;
                    cop_result   <= cop_mem_error ? RES_BUS_ERR : RES_OK;
                end
                ST_RSP: begin
                    if (cpu_insn_ack) begin
                        state        <= ST_IDLE;
                        cop_insn_rsp <= 1'b0;
                        cop_wen      <= 1'b0;
                        cop_waddr    <= 5'h0;
                        cop_wdata    <= 32'h0;
                        cop_result   <= RES_OK;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scarv_cop_core.sv
// tb_scarv_cop_core: directed self-checking bench for scarv_cop_core.
// Memory is modelled by a small negedge responder with a stall budget.
module tb_scarv_cop_core;

    localparam logic [2:0] F_MV2COP = 3'd0;
    localparam logic [2:0] F_MV2GPR = 3'd1;
    localparam logic [2:0] F_LDW    = 3'd2;
    localparam logic [2:0] F_STW    = 3'd3;
    localparam logic [2:0] F_RNG    = 3'd4;
    localparam logic [2:0] F_ADD    = 3'd5;
    localparam logic [2:0] F_XOR    = 3'd6;
    localparam logic [2:0] F_INV    = 3'd7;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        g_clk_req;
    logic        cpu_insn_req = 1'b0;
    logic        cop_insn_ack;
    logic        cpu_abort_req = 1'b0;
    logic [31:0] cpu_insn_enc = 32'h0;
    logic [31:0] cpu_rs1 = 32'h0;
    logic        cop_wen;
    logic [4:0]  cop_waddr;
    logic [31:0] cop_wdata;
    logic [2:0]  cop_result;
    logic        cop_insn_rsp;
    logic        cpu_insn_ack = 1'b0;
    logic [31:0] cop_random;
    logic        cop_rand_sample;
    logic        cop_mem_cen;
    logic        cop_mem_wen;
    logic [31:0] cop_mem_addr;
    logic [31:0] cop_mem_wdata;
    logic [31:0] cop_mem_rdata = 32'h0;
    logic [3:0]  cop_mem_ben;
    logic        cop_mem_stall = 1'b0;
    logic        cop_mem_error = 1'b0;

    scarv_cop_core #(.LFSR_SEED(32'h0000_0001)) dut (
        .g_clk           (g_clk),
        .g_resetn        (g_resetn),
        .g_clk_req       (g_clk_req),
        .cpu_insn_req    (cpu_insn_req),
        .cop_insn_ack    (cop_insn_ack),
        .cpu_abort_req   (cpu_abort_req),
        .cpu_insn_enc    (cpu_insn_enc),
        .cpu_rs1         (cpu_rs1),
        .cop_wen         (cop_wen),
        .cop_waddr       (cop_waddr),
        .cop_wdata       (cop_wdata),
        .cop_result      (cop_result),
        .cop_insn_rsp    (cop_insn_rsp),
        .cpu_insn_ack    (cpu_insn_ack),
        .cop_random      (cop_random),
        .cop_rand_sample (cop_rand_sample),
        .cop_mem_cen     (cop_mem_cen),
        .cop_mem_wen     (cop_mem_wen),
        .cop_mem_addr    (cop_mem_addr),
        .cop_mem_wdata   (cop_mem_wdata),
        .cop_mem_rdata   (cop_mem_rdata),
        .cop_mem_ben     (cop_mem_ben),
        .cop_mem_stall   (cop_mem_stall),
        .cop_mem_error   (cop_mem_error)
    );

    always #5 g_clk = ~g_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3,
                                       input logic [4:0] rd,
                                       input logic [3:0] cs1,
                                       input logic [3:0] cs2,
                                       input logic [7:0] imm);
        return {imm, cs2, cs1, 1'b0, f3, rd, 7'b0101011};
    endfunction

    // Memory responder and observers.
    int          stall_left = 0;
    int          cen_cycles = 0;
    int          unstable   = 0;
    int          pulses     = 0;
    logic [31:0] snap_addr, snap_wdata, rng_seen;
    logic        snap_wen;
    logic [3:0]  snap_ben;

    always @(negedge g_clk) begin
        if (cop_mem_cen) begin
            cen_cycles++;
            if (cen_cycles == 1) begin
                snap_addr  = cop_mem_addr;
                snap_wdata = cop_mem_wdata;
                snap_wen   = cop_mem_wen;
                snap_ben   = cop_mem_ben;
            end else if (cop_mem_addr !== snap_addr ||
                         cop_mem_wdata !== snap_wdata ||
                         cop_mem_wen !== snap_wen ||
                         cop_mem_ben !== snap_ben) begin
                unstable++;
            end
        end
        if (cop_mem_cen && stall_left > 0) begin
            cop_mem_stall = 1'b1;
            stall_left--;
        end else begin
            cop_mem_stall = 1'b0;
        end
        if (cop_rand_sample) begin
            pulses++;
            rng_seen = cop_random;
        end
    end

    task automatic issue(input logic [31:0] enc, input logic [31:0] rs1);
        int t = 0;
        @(negedge g_clk);
        while (!cop_insn_ack && t < 50) begin
            @(negedge g_clk);
            t++;
        end
        if (!cop_insn_ack) check("accept_timeout", 32'd0, 32'd1);
        cpu_insn_req = 1'b1;
        cpu_insn_enc = enc;
        cpu_rs1      = rs1;
        @(posedge g_clk);
        #1 cpu_insn_req = 1'b0;
    endtask

    task automatic finish(input int hold, output logic [2:0] res,
                          output logic wen, output logic [4:0] waddr,
                          output logic [31:0] wdata, output logic stable);
        int t = 0;
        @(negedge g_clk);
        while (!cop_insn_rsp && t < 50) begin
            @(negedge g_clk);
            t++;
        end
        if (!cop_insn_rsp) check("rsp_timeout", 32'd0, 32'd1);
        res    = cop_result;
        wen    = cop_wen;
        waddr  = cop_waddr;
        wdata  = cop_wdata;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge g_clk);
            if (cop_insn_rsp !== 1'b1 || cop_result !== res ||
                cop_wen !== wen || cop_waddr !== waddr ||
                cop_wdata !== wdata || cop_insn_ack !== 1'b0)
                stable = 1'b0;
        end
        cpu_insn_ack = 1'b1;
        @(posedge g_clk);
        #1 cpu_insn_ack = 1'b0;
    endtask

    task automatic run(input logic [31:0] enc, input logic [31:0] rs1,
                       output logic [2:0] res, output logic wen,
                       output logic [4:0] waddr, output logic [31:0] wdata);
        logic st;
        issue(enc, rs1);
        finish(0, res, wen, waddr, wdata, st);
    endtask

    task automatic read_cpr(input logic [3:0] idx, output logic [31:0] v);
        logic [2:0] r;
        logic       w;
        logic [4:0] a;
        run(mk(F_MV2GPR, 5'd1, idx, 4'd0, 8'd0), 32'h0, r, w, a, v);
    endtask

    logic [2:0]  res;
    logic        wen, stable;
    logic [4:0]  waddr;
    logic [31:0] wdata, v;
    logic [31:0] bad;

    initial begin
        repeat (3) @(posedge g_clk);
        @(negedge g_clk);
        check("rst_random", cop_random, 32'h1);
        check("rst_rsp", {31'h0, cop_insn_rsp}, 32'h0);
        check("rst_cen", {31'h0, cop_mem_cen}, 32'h0);
        check("rst_wen", {31'h0, cop_wen}, 32'h0);
        check("rst_result", {29'h0, cop_result}, 32'h0);
        check("rst_ack", {31'h0, cop_insn_ack}, 32'h1);
        g_resetn = 1'b1;

        run(mk(F_MV2COP, 5'd3, 4'd0, 4'd0, 8'd0), 32'hDEAD_BEEF,
            res, wen, waddr, wdata);
        check("mv2cop_res", {29'h0, res}, 32'h0);
        check("mv2cop_wen", {31'h0, wen}, 32'h0);
        check("mv2cop_wdata", wdata, 32'h0);

        run(mk(F_MV2GPR, 5'd5, 4'd3, 4'd0, 8'd0), 32'h0,
            res, wen, waddr, wdata);
        check("mv2gpr_res", {29'h0, res}, 32'h0);
        check("mv2gpr_wen", {31'h0, wen}, 32'h1);
        check("mv2gpr_waddr", {27'h0, waddr}, 32'd5);
        check("mv2gpr_wdata", wdata, 32'hDEAD_BEEF);

        run(mk(F_MV2COP, 5'd1, 4'd0, 4'd0, 8'd0), 32'h5,
            res, wen, waddr, wdata);
        run(mk(F_MV2COP, 5'd2, 4'd0, 4'd0, 8'd0), 32'hFFFF_FFFE,
            res, wen, waddr, wdata);
        run(mk(F_ADD, 5'd4, 4'd1, 4'd2, 8'd0), 32'h0,
            res, wen, waddr, wdata);
        check("add_res", {29'h0, res}, 32'h0);
        read_cpr(4'd4, v);
        check("add_val", v, 32'h3);
        run(mk(F_XOR, 5'd6, 4'd1, 4'd2, 8'd0), 32'h0,
            res, wen, waddr, wdata);
        read_cpr(4'd6, v);
        check("xor_val", v, 32'hFFFF_FFFB);

        cen_cycles = 0;
        unstable   = 0;
        stall_left = 3;
        run(mk(F_STW, 5'd0, 4'd3, 4'd0, 8'h01), 32'h100,
            res, wen, waddr, wdata);
        check("st_res", {29'h0, res}, 32'h0);
        check("st_cen_cycles", cen_cycles, 32'd4);
        check("st_stable", unstable, 32'd0);
        check("st_addr", snap_addr, 32'h104);
        check("st_wen", {31'h0, snap_wen}, 32'h1);
        check("st_ben", {28'h0, snap_ben}, 32'hF);
        check("st_wdata", snap_wdata, 32'hDEAD_BEEF);

        cen_cycles    = 0;
        cop_mem_rdata = 32'h1234_5678;
        run(mk(F_LDW, 5'd7, 4'd0, 4'd0, 8'hFF), 32'h200,
            res, wen, waddr, wdata);
        check("ld_res", {29'h0, res}, 32'h0);
        check("ld_addr", snap_addr, 32'h1FC);
        check("ld_memwen", {31'h0, snap_wen}, 32'h0);
        check("ld_ben", {28'h0, snap_ben}, 32'h0);
        read_cpr(4'd7, v);
        check("ld_val", v, 32'h1234_5678);

        cen_cycles = 0;
        run(mk(F_LDW, 5'd7, 4'd0, 4'd0, 8'h00), 32'h101,
            res, wen, waddr, wdata);
        check("mis_res", {29'h0, res}, 32'd3);
        check("mis_cen", cen_cycles, 32'd0);

        cop_mem_rdata = 32'hAAAA_AAAA;
        cop_mem_error = 1'b1;
        run(mk(F_LDW, 5'd7, 4'd0, 4'd0, 8'h00), 32'h300,
            res, wen, waddr, wdata);
        cop_mem_error = 1'b0;
        check("buserr_res", {29'h0, res}, 32'd2);
        check("buserr_wen", {31'h0, wen}, 32'h0);
        read_cpr(4'd7, v);
        check("buserr_keep", v, 32'h1234_5678);

        bad = mk(F_MV2COP, 5'd3, 4'd0, 4'd0, 8'd0);
        bad[6:0] = 7'h33;
        run(bad, 32'h1111_1111, res, wen, waddr, wdata);
        check("badop_res", {29'h0, res}, 32'd4);
        check("badop_wen", {31'h0, wen}, 32'h0);
        read_cpr(4'd3, v);
        check("badop_keep", v, 32'hDEAD_BEEF);

        run(mk(F_INV, 5'd5, 4'd3, 4'd0, 8'd0), 32'h0,
            res, wen, waddr, wdata);
        check("f3inv_res", {29'h0, res}, 32'd4);
        check("f3inv_wen", {31'h0, wen}, 32'h0);

        issue(mk(F_MV2GPR, 5'd9, 4'd3, 4'd0, 8'd0), 32'h0);
        finish(5, res, wen, waddr, wdata, stable);
        check("hold_stable", {31'h0, stable}, 32'h1);
        check("hold_wdata", wdata, 32'hDEAD_BEEF);
        check("hold_waddr", {27'h0, waddr}, 32'd9);

        pulses = 0;
        run(mk(F_RNG, 5'd8, 4'd0, 4'd0, 8'd0), 32'h0,
            res, wen, waddr, wdata);
        check("rng_res", {29'h0, res}, 32'h0);
        check("rng_pulses", pulses, 32'd1);
        read_cpr(4'd8, v);
        check("rng_val", v, rng_seen);

        cen_cycles = 0;
        stall_left = 100;
        issue(mk(F_LDW, 5'd9, 4'd0, 4'd0, 8'd0), 32'h400);
        repeat (2) @(negedge g_clk);
        check("abort_cen_before", {31'h0, cop_mem_cen}, 32'h1);
        cpu_abort_req = 1'b1;
        @(posedge g_clk);
        #1 cpu_abort_req = 1'b0;
        @(negedge g_clk);
        check("abort_cen_drop", {31'h0, cop_mem_cen}, 32'h0);
        stall_left = 0;
        finish(0, res, wen, waddr, wdata, stable);
        check("abort_res", {29'h0, res}, 32'd1);
        read_cpr(4'd9, v);
        check("abort_keep", v, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/scarv_cop_core.md
Name: scarv_cop_core

Overview:
Cryptographic coprocessor (subset) attached to a RISC-V CPU. It holds sixteen 32-bit coprocessor registers (CPRs) c0..c15 and accepts one instruction at a time over a req/ack handshake. It executes the instruction using the CPRs, the CPU-supplied rs1 value, a word-wide memory port and an internal LFSR random source. It returns a GPR writeback plus a 3-bit result code over a rsp/ack handshake.

Parameters:
LFSR_SEED, 32'h0000_0001, LFSR reset value; must be non-zero.

Ports:
g_clk  in  1  global clock; the block uses one clock.
g_resetn  in  1  reset; synchronous, active-low.
g_clk_req  out  1  clock request: state!=IDLE or cpu_insn_req.
cpu_insn_req  in  1  instruction request.
cop_insn_ack  out  1  accept; high only in IDLE.
cpu_abort_req  in  1  abort in-flight instruction.
cpu_insn_enc  in  32  instruction encoding.
cpu_rs1  in  32  GPR rs1 value.
cop_wen  out  1  GPR write enable.
cop_waddr  out  5  GPR destination.
cop_wdata  out  32  GPR write data.
cop_result  out  3  result code.
cop_insn_rsp  out  1  result valid.
cpu_insn_ack  in  1  CPU accepts result.
cop_random  out  32  current LFSR state.
cop_rand_sample  out  1  one-cycle pulse when a random sample is consumed.
cop_mem_cen  out  1  memory request.
cop_mem_wen  out  1  write (1) / read (0).
cop_mem_addr  out  32  byte address, always word aligned.
cop_mem_wdata  out  32  store data.
cop_mem_rdata  in  32  load data.
cop_mem_ben  out  4  byte enables; 4'b1111 on store, 0 on load.
cop_mem_stall  in  1  memory not ready.
cop_mem_error  in  1  bus error.

Behaviour:
- Handshakes: accept = cpu_insn_req & cop_insn_ack. Accept latches enc and rs1. Finish = cop_insn_rsp & cpu_insn_ack. Rsp outputs are held stable until finish. The next cycle returns to IDLE (no accept in the finish cycle).
- FSM states: IDLE -> EXEC -> RSP for non-memory ops. Memory ops go IDLE -> MEM_REQ -> MEM_RSP -> RSP. RSP -> IDLE on finish.
- Non-memory latency: rsp asserted the cycle after accept.
- Encoding: opcode [6:0] must be 7'b0101011. rd=[11:7], cd=[10:7], cs1=[19:16], cs2=[23:20], funct3=[14:12]. off = sign-extended [31:24] shifted left 2. addr = rs1 + off.
- funct3 0 MV2COP: c[cd]=rs1.
- funct3 1 MV2GPR: wen=1, waddr=rd, wdata=c[cs1].
- funct3 2 LD.W: c[cd]=mem[addr].
- funct3 3 ST.W: mem[addr]=c[cs1].
- funct3 4 RNGSAMP: c[cd]=cop_random; cop_rand_sample pulses.
- funct3 5 ADD: c[cd]=c[cs1]+c[cs2] mod 2^32.
- funct3 6 XOR: c[cd]=c[cs1]^c[cs2].
- funct3 7: invalid.
- cop_wen=0 for every instruction except successful MV2GPR. When wen=0: waddr=0, wdata=0.
- Result codes: 0 OK, 1 ABORT, 2 BUS_ERR, 3 MISALIGN, 4 INVALID.
- Any non-OK result: no CPR write, no GPR write.
- LD.W/ST.W with addr[1:0]!=0: MISALIGN, no memory request issued.
- Memory transaction: cen held with addr/wen/wdata/ben stable from MEM_REQ until a cycle with stall=0. rdata and error are sampled in the following cycle (MEM_RSP). error=1 gives BUS_ERR.
- Abort: cpu_abort_req sampled in EXEC or MEM_REQ gives ABORT. If sampled in MEM_REQ, cen drops next cycle. Abort is ignored in IDLE, MEM_RSP and RSP.
- LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1. Advances every cycle after reset and loads LFSR_SEED in reset.
- Reset values: CPRs 0; state IDLE; rsp, wen, cen, rand_sample = 0; waddr, wdata, result, addr, wdata, ben = 0. Reset mid-instruction discards the instruction.

Decomposition:
- Package scarv_cop_pkg holds: opcode constant, funct3 enums, result-code constants, FSM state enum, LFSR taps.
- Sub-module scarv_cop_cprs: 16x32 register file, 2 combinational read ports, 1 synchronous write port.

Test Plan:
- MV2COP rs1=0xDEADBEEF to c3, then MV2GPR cs1=3 rd=5 -> wen=1, waddr=5, wdata=0xDEADBEEF, result=0.
- c1=5, c2=0xFFFFFFFE, ADD cd=4 -> MV2GPR reads 3. XOR of the same operands -> 0xFFFFFFFB.
- ST.W c3, rs1=0x100, off=+4 -> cen=1, wen=1, addr=0x104, ben=0xF, wdata=c3, held through 3 stall cycles. LD.W with rdata=0x12345678 -> the CPR holds it.
- LD.W rs1=0x101 -> result=3, cen never asserts. Load with mem_error=1 -> result=2, target CPR unchanged.
- Opcode 0x33 or funct3=7 -> result=4, wen=0. Hold cpu_insn_ack=0 for 5 cycles -> rsp and outputs stable.
- RNGSAMP -> cop_rand_sample pulses once, CPR equals cop_random of that cycle. Abort during a stalled load -> result=1, cen drops.
